// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared control encodings and pipeline control bundles for the memory stage
package riscv_ctrl_pkg;
  localparam int RESULTSRC_W = 3;
  localparam int DEXT_W = 3;
  localparam logic [1:0] OPC_BRANCH_CLASS = 2'b11;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef struct packed {
    logic                   reg_write;
    logic                   mem_write;
    logic [RESULTSRC_W-1:0] result_src;
    logic [DEXT_W-1:0]      dext;
  } m_ctrl_t;
  typedef struct packed {
    logic                   reg_write;
    logic [RESULTSRC_W-1:0] result_src;
    logic [DEXT_W-1:0]      dext;
  } w_ctrl_t;
endpackage

// File: rtl/branch_cond.sv
// branch_cond: decodes ALU flags into a branch-taken condition from funct3
module branch_cond
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       neg,
  input  logic       carry,
  input  logic       ovf,
  output logic       cond
);
  always_comb begin
    cond = funct3 == F3_BEQ  ? zero :
           funct3 == F3_BNE  ? !zero :
           funct3 == F3_BLT  ? (neg ^ ovf) :
           funct3 == F3_BGE  ? !(neg ^ ovf) :
           funct3 == F3_BLTU ? !carry :
           funct3 == F3_BGEU ? carry : 1'b0;
  end
endmodule

// File: rtl/memory_stage_cu.sv
// memory_stage_cu: EX->MEM->WB control pipeline with branch redirect and stall bubbles.
// BRANCH_STATS_EN enables saturating branch/taken statistics counters.
module memory_stage_cu
  import riscv_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RegWriteE,
  input  logic                   MemWriteE,
  input  logic                   JumpE,
  input  logic                   BranchE,
  input  logic [RESULTSRC_W-1:0] ResultSrcE,
  input  logic [DEXT_W-1:0]      DextControlE,
  input  logic [2:0]             funct3E,
  input  logic [1:0]             opE_65,
  input  logic                   ZeroE,
  input  logic                   NegE,
  input  logic                   CarryE,
  input  logic                   OverflowE,
  input  logic                   StallM,
  output logic                   PCSrcE,
  output logic                   RegWriteM,
  output logic                   MemWriteM,
  output logic [RESULTSRC_W-1:0] ResultSrcM,
  output logic [DEXT_W-1:0]      DextControlM,
  output logic                   RegWriteW,
  output logic [RESULTSRC_W-1:0] ResultSrcW,
  output logic [DEXT_W-1:0]      DextControlW,
  output logic [31:0]            BranchCount,
  output logic [31:0]            TakenCount
);
  logic    cond;
  logic    is_branch;
  m_ctrl_t m_d, m_q;
  w_ctrl_t w_d, w_q;
  branch_cond u_cond (
    .funct3(funct3E),
    .zero  (ZeroE),
    .neg   (NegE),
    .carry (CarryE),
    .ovf   (OverflowE),
    .cond  (cond)
  );
  // A stall holds M in place and feeds a bubble into W so the held op retires once.
  always_comb begin
    is_branch = BranchE && opE_65 == OPC_BRANCH_CLASS;
    PCSrcE    = !reset && (JumpE || (is_branch && cond));
    m_d = reset ? '0 : StallM ? m_q : '{RegWriteE, MemWriteE, ResultSrcE, DextControlE};
    w_d = (reset || StallM) ? '0 : '{m_q.reg_write, m_q.result_src, m_q.dext};
  end
  always_ff @(posedge clk) begin
    m_q <= m_d;
    w_q <= w_d;
  end
  assign RegWriteM    = m_q.reg_write;
  assign MemWriteM    = m_q.mem_write;
  assign ResultSrcM   = m_q.result_src;
  assign DextControlM = m_q.dext;
  assign RegWriteW    = w_q.reg_write;
  assign ResultSrcW   = w_q.result_src;
  assign DextControlW = w_q.dext;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_d, branch_cnt_q;
  logic [31:0] taken_cnt_d, taken_cnt_q;
  always_comb begin
    branch_cnt_d = reset ? '0 :
                   (!StallM && is_branch && branch_cnt_q != '1) ? branch_cnt_q + 32'd1 : branch_cnt_q;
    taken_cnt_d  = reset ? '0 :
                   (!StallM && is_branch && cond && taken_cnt_q != '1) ? taken_cnt_q + 32'd1 : taken_cnt_q;
  end
  always_ff @(posedge clk) begin
    branch_cnt_q <= branch_cnt_d;
    taken_cnt_q  <= taken_cnt_d;
  end
  assign BranchCount = branch_cnt_q;
  assign TakenCount  = taken_cnt_q;
`else
  assign BranchCount = 32'h0;
  assign TakenCount  = 32'h0;
`endif
endmodule

// File: tb/tb_memory_stage_cu.sv
// tb_memory_stage_cu: directed self-checking bench for memory_stage_cu
module tb_memory_stage_cu;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, RegWriteE, MemWriteE, JumpE, BranchE;
  logic [2:0] ResultSrcE, DextControlE, funct3E;
  logic [1:0] opE_65;
  logic ZeroE, NegE, CarryE, OverflowE, StallM;
  logic PCSrcE, RegWriteM, MemWriteM, RegWriteW;
  logic [2:0] ResultSrcM, DextControlM, ResultSrcW, DextControlW;
  logic [31:0] BranchCount, TakenCount;
  int n_checks = 0;
  int n_fail = 0;
  memory_stage_cu dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ResultSrcE(ResultSrcE), .DextControlE(DextControlE), .funct3E(funct3E), .opE_65(opE_65),
    .ZeroE(ZeroE), .NegE(NegE), .CarryE(CarryE), .OverflowE(OverflowE), .StallM(StallM),
    .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .DextControlM(DextControlM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .DextControlW(DextControlW),
    .BranchCount(BranchCount), .TakenCount(TakenCount)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] cnt(input logic [31:0] v);
    return STATS ? v : 32'h0;
  endfunction
  task automatic chk_m(input string tag, input logic rw, input logic mw, input logic [2:0] rs, input logic [2:0] dx);
    chk({tag, ".RegWriteM"}, {31'h0, RegWriteM}, {31'h0, rw});
    chk({tag, ".MemWriteM"}, {31'h0, MemWriteM}, {31'h0, mw});
    chk({tag, ".ResultSrcM"}, {29'h0, ResultSrcM}, {29'h0, rs});
    chk({tag, ".DextControlM"}, {29'h0, DextControlM}, {29'h0, dx});
  endtask
  task automatic chk_w(input string tag, input logic rw, input logic [2:0] rs, input logic [2:0] dx);
    chk({tag, ".RegWriteW"}, {31'h0, RegWriteW}, {31'h0, rw});
    chk({tag, ".ResultSrcW"}, {29'h0, ResultSrcW}, {29'h0, rs});
    chk({tag, ".DextControlW"}, {29'h0, DextControlW}, {29'h0, dx});
  endtask
  task automatic chk_cnt(input string tag, input logic [31:0] b, input logic [31:0] t);
    chk({tag, ".BranchCount"}, BranchCount, cnt(b));
    chk({tag, ".TakenCount"}, TakenCount, cnt(t));
  endtask
  task automatic chk_pc(input string tag, input logic exp);
    #1;
    chk({tag, ".PCSrcE"}, {31'h0, PCSrcE}, {31'h0, exp});
  endtask
  initial begin
    reset = 1; RegWriteE = 0; MemWriteE = 0; JumpE = 1; BranchE = 0;
    ResultSrcE = 0; DextControlE = 0; funct3E = 0; opE_65 = 0;
    ZeroE = 0; NegE = 0; CarryE = 0; OverflowE = 0; StallM = 0;
    chk_pc("reset_jump", 1'b0);
    step(); step();
    chk_m("reset", 0, 0, 0, 0);
    chk_w("reset", 0, 0, 0);
    chk_cnt("reset", 0, 0);
    reset = 0; JumpE = 0;
    BranchE = 1; opE_65 = 2'b11; funct3E = 3'b000; ZeroE = 1;
    chk_pc("beq_taken", 1'b1);
    step();
    chk_cnt("beq", 1, 1);
    funct3E = 3'b100; ZeroE = 0; NegE = 0; OverflowE = 1;
    chk_pc("blt_ovf", 1'b1);
    step();
    chk_cnt("blt", 2, 2);
    funct3E = 3'b111; CarryE = 0; OverflowE = 0;
    chk_pc("bgeu_nc", 1'b0);
    step();
    chk_cnt("bgeu", 3, 2);
    funct3E = 3'b110;
    chk_pc("bltu_nc", 1'b1);
    funct3E = 3'b101; NegE = 1;
    chk_pc("bge_neg", 1'b0);
    funct3E = 3'b010; ZeroE = 1; CarryE = 1;
    chk_pc("f3_010", 1'b0);
    funct3E = 3'b001;
    chk_pc("bne_zero", 1'b0);
    funct3E = 3'b000; opE_65 = 2'b01;
    chk_pc("beq_not_branch_op", 1'b0);
    JumpE = 1;
    chk_pc("jump", 1'b1);
    JumpE = 0; BranchE = 0; opE_65 = 2'b11;
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 3'b010; DextControlE = 3'b101;
    step();
    chk_m("pipe_e1", 1, 1, 3'b010, 3'b101);
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; DextControlE = 0;
    step();
    chk_w("pipe_e2", 1, 3'b010, 3'b101);
    chk_m("pipe_e2", 0, 0, 0, 0);
    chk_cnt("pipe", 3, 2);
    RegWriteE = 1; ResultSrcE = 3'b011; DextControlE = 3'b010;
    BranchE = 1; funct3E = 3'b000; ZeroE = 1;
    step();
    chk_cnt("stall_load", 4, 3);
    RegWriteE = 0; ResultSrcE = 3'b001; DextControlE = 3'b111; StallM = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_m("stall_hold", 1, 0, 3'b011, 3'b010);
      chk_w("stall_bubble", 0, 0, 0);
      chk_cnt("stall_cnt", 4, 3);
    end
    StallM = 0;
    step();
    chk_w("release", 1, 3'b011, 3'b010);
    chk_m("release", 0, 0, 3'b001, 3'b111);
    chk_cnt("release", 5, 4);
    BranchE = 0;
    step();
    chk_w("release_once", 0, 3'b001, 3'b111);
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 3'b110; DextControlE = 3'b011;
    step();
    StallM = 1; reset = 1; JumpE = 1;
    chk_pc("reset_stall_jump", 1'b0);
    step();
    chk_m("reset_stall", 0, 0, 0, 0);
    chk_w("reset_stall", 0, 0, 0);
    chk_cnt("reset_stall", 0, 0);
    reset = 0; StallM = 0; JumpE = 0;
    RegWriteE = 1; MemWriteE = 0; ResultSrcE = 3'b100; DextControlE = 3'b011;
    step();
    chk_m("post_reset", 1, 0, 3'b100, 3'b011);
    chk_w("post_reset", 0, 0, 0);
`ifdef BRANCH_STATS_EN
    @(negedge clk);
    force dut.branch_cnt_q = 32'hFFFF_FFFE;
    force dut.taken_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt_q;
    release dut.taken_cnt_q;
`endif
    BranchE = 1; opE_65 = 2'b11; funct3E = 3'b000; ZeroE = 1;
    step();
    chk_cnt("sat1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(); step();
    chk_cnt("sat3", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    BranchE = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_stage_cu.md
MEMORY_STAGE_CU -- requirements
Module: memory_stage_cu

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset; clock clk.
REQ-003 SHALL have ports from the execute control register:
- RegWriteE, MemWriteE, JumpE, BranchE  input  1 each
- ResultSrcE  input  3
- DextControlE  input  3
- funct3E  input  3
- opE_65  input  2
REQ-004 SHALL have ports: ZeroE, NegE, CarryE, OverflowE  input  1 each  ALU flags for the instruction in execute.
REQ-005 SHALL have port: StallM  input  1  data-memory wait; holds the memory stage.
REQ-006 SHALL have port: PCSrcE  output  1  redirect fetch (taken branch or jump).
REQ-007 SHALL have ports, EX->MEM control: RegWriteM, MemWriteM (1); ResultSrcM, DextControlM (3)  output.
REQ-008 SHALL have ports, MEM->WB control: RegWriteW (1); ResultSrcW, DextControlW (3)  output.
REQ-009 SHALL have ports: BranchCount, TakenCount  output  32 each  branch statistics.

Function
REQ-010 PCSrcE SHALL be combinational: JumpE OR (BranchE AND opE_65==2'b11 AND cond).
REQ-011 cond SHALL be decoded from funct3E:
- 000: Zero
- 001: !Zero
- 100: Neg^Ovf
- 101: !(Neg^Ovf)
- 110: !Carry
- 111: Carry
- 010/011: 0
REQ-012 PCSrcE SHALL be forced 0 while reset is high.
REQ-013 With StallM=0, the EX->MEM register SHALL capture the E-side control signals every rising edge; latency 1 cycle.
REQ-014 With StallM=0, the MEM->WB register SHALL capture the M-side outputs every rising edge; E->W latency 2 cycles.
REQ-015 With StallM=1, the M-side outputs SHALL hold their values.
REQ-016 With StallM=1, RegWriteW SHALL load 0 (bubble), and ResultSrcW and DextControlW SHALL load 000.
REQ-017 With StallM=1, the E-side inputs SHALL be ignored; upstream holds execute.
REQ-018 When StallM deasserts, the held M instruction SHALL advance to W on the next edge, exactly once.
REQ-019 MemWriteM SHALL NOT be duplicated into W; there are no W-side memory-write outputs.

Reset
REQ-020 On reset, all M and W outputs SHALL be 0 and BranchCount = TakenCount = 0 at the next edge.
REQ-021 Reset SHALL take priority over StallM and over counter increments.
REQ-022 Reset asserted mid-stall SHALL discard the held instruction; after reset, the first edge with reset=0 loads the E-side inputs normally.

Configuration
REQ-023 Macro BRANCH_STATS_EN SHALL control the statistics counters.
REQ-024 With BRANCH_STATS_EN defined, on each edge with reset=0 and StallM=0:
- BranchCount SHALL increment when BranchE=1 and opE_65==2'b11
- TakenCount SHALL increment when that condition holds and cond=1
REQ-025 Both counters SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-026 Without BRANCH_STATS_EN, the counter ports SHALL remain present and be tied to 32'h0, with no counter flops.

Structure
REQ-027 Shared package riscv_ctrl_pkg SHALL hold:
- the funct3 branch encodings (BEQ, BNE, BLT, BGE, BLTU, BGEU)
- OPC_BRANCH_CLASS = 2'b11
- RESULTSRC_W = 3 and DEXT_W = 3
REQ-028 The flag-to-condition decode SHALL be a combinational sub-module branch_cond (inputs funct3, Zero, Neg, Carry, Ovf; output cond), instantiated once.
REQ-029 No other sub-modules SHALL be used.

Verification
REQ-030 BEQ with equal operands: funct3E=000, BranchE=1, opE_65=11, ZeroE=1 -> PCSrcE=1 same cycle; TakenCount +1 (macro on).
REQ-031 BLT with signed overflow: funct3E=100, NegE=0, OverflowE=1 -> PCSrcE=1. BGEU with CarryE=0, funct3E=111 -> PCSrcE=0; BranchCount +1, TakenCount unchanged.
REQ-032 Pipeline latency: RegWriteE=1, ResultSrcE=010, DextControlE=101 with StallM=0 -> RegWriteM=1 and ResultSrcM=010 after edge 1; RegWriteW=1, ResultSrcW=010, DextControlW=101 after edge 2.
REQ-033 Stall: hold StallM=1 for 3 cycles with an M instruction present:
- M outputs constant and RegWriteW=0 for 3 cycles
- after release, RegWriteW=1 for exactly one cycle
- counters do not advance during the stall
REQ-034 Reset mid-stall: StallM=1, reset=1 -> all outputs 0 and counters 0 next edge; JumpE=1 during reset -> PCSrcE=0.
REQ-035 Saturation: preload the counters to 32'hFFFFFFFE via force, then apply 3 taken branches -> both counters end at 32'hFFFFFFFF. Without the macro, both counters read 0 throughout.
